// File: rtl/mem_stage.sv
// mem_stage: pipeline stage between execute and writeback.
//
// Holds one instruction from execute. If that instruction issued a data-memory
// request, the stage waits for the matching response, extracts and extends the
// load data, and then presents the writeback and register-file buses.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   es2ms_valid/bus     instruction from execute
//   ms_allowin          stage can take a new instruction this cycle
//   data_sram_data_ok   response strobe, one per request, in order
//   data_sram_rdata     response data, valid with data_ok
//   ws_allowin          writeback can accept
//   ms2ws_valid/bus     {vaddr, pc, csr_zip, except_zip} to writeback
//   ms_rf_zip           {csr_re, rf_we, rf_waddr, rf_wdata} forwarding view
//   ms_load_pending     load still waiting for data (decode stalls on it)
//   ms_ex               held instruction carries an exception or ertn
//   wb_ex, ertn_flush   pipeline flush from writeback
module mem_stage #(
    parameter int ES2MS_LEN = 195,
    parameter int MS2WS_LEN = 150
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 es2ms_valid,
    input  logic [ES2MS_LEN-1:0] es2ms_bus,
    output logic                 ms_allowin,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 ws_allowin,
    output logic                 ms2ws_valid,
    output logic [MS2WS_LEN-1:0] ms2ws_bus,
    output logic [38:0]          ms_rf_zip,
    output logic                 ms_load_pending,
    output logic                 ms_ex,
    input  logic                 wb_ex,
    input  logic                 ertn_flush
);

    typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_t;

    logic                 ms_valid;
    logic [ES2MS_LEN-1:0] es_bus_q;
    logic                 discard;
    logic [31:0]          data_buf;
    buf_state_t           buf_state, buf_next;
    logic                 data_buf_valid;
    logic                 buf_fill;

    logic        flush;
    logic        ready_go;
    logic [31:0] pc_q, vaddr_q, result_q;
    logic [78:0] csr_zip_q;
    logic [6:0]  except_zip_q;
    logic [4:0]  load_op_q, rf_waddr_q;
    logic        mem_req_q, csr_re_q, rf_we_q_raw;
    logic [31:0] mem_data, mem_shift, load_value, rf_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        rf_we_q;

    assign {pc_q, vaddr_q, csr_zip_q, except_zip_q, load_op_q, mem_req_q,
            csr_re_q, rf_we_q_raw, rf_waddr_q, result_q} = es_bus_q;

    assign flush = wb_ex | ertn_flush;

    // A response that belongs to a flushed request must not release the
    // instruction captured after the flush.
    assign ready_go    = ~mem_req_q | data_buf_valid | (data_sram_data_ok & ~discard);
    assign ms_allowin  = ~ms_valid | (ready_go & ws_allowin);
    assign ms2ws_valid = ms_valid & ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           ms_valid <= 1'b0;
        else if (flush)      ms_valid <= 1'b0;
        else if (ms_allowin) ms_valid <= es2ms_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      es_bus_q <= '0;
        else if (es2ms_valid && ms_allowin && !flush)   es_bus_q <= es2ms_bus;
    end

    // Outstanding request at flush time: its response will still arrive and
    // has to be swallowed. If data_ok coincides with the flush it is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            discard <= 1'b0;
        else if (flush && ms_valid && mem_req_q && !data_buf_valid && !data_sram_data_ok)
            discard <= 1'b1;
        else if (data_sram_data_ok)
            discard <= 1'b0;
    end

    // Response buffer: keeps data that arrived while writeback was stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) buf_state <= BUF_EMPTY;
        else       buf_state <= buf_next;
    end

    always_comb begin
        buf_next = buf_state;
        case (buf_state)
            BUF_EMPTY:
                if (!flush && ms_valid && mem_req_q && data_sram_data_ok && !discard && !ws_allowin)
                    buf_next = BUF_FULL;
            BUF_FULL:
                if (flush || (ms2ws_valid && ws_allowin))
                    buf_next = BUF_EMPTY;
            default: buf_next = BUF_EMPTY;
        endcase
    end

    always_comb begin
        data_buf_valid = (buf_state == BUF_FULL);
        buf_fill       = (buf_state == BUF_EMPTY) && (buf_next == BUF_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         data_buf <= '0;
        else if (buf_fill) data_buf <= data_sram_rdata;
    end

    // Load extraction; load_op is {ld_b, ld_bu, ld_h, ld_hu, ld_w}.
    assign mem_data  = data_buf_valid ? data_buf : data_sram_rdata;
    assign mem_shift = mem_data >> {vaddr_q[1:0], 3'b000};
    assign load_byte = mem_shift[7:0];
    assign load_half = vaddr_q[1] ? mem_data[31:16] : mem_data[15:0];

    always_comb begin
        load_value = mem_data;
        if (load_op_q[4])      load_value = {{24{load_byte[7]}}, load_byte};
        else if (load_op_q[3]) load_value = {24'b0, load_byte};
        else if (load_op_q[2]) load_value = {{16{load_half[15]}}, load_half};
        else if (load_op_q[1]) load_value = {16'b0, load_half};
    end

    assign rf_wdata = (|load_op_q) ? load_value : result_q;

    assign ms_ex           = ms_valid & (|except_zip_q);
    assign rf_we_q         = rf_we_q_raw & ms_valid & ~ms_ex;
    assign ms_load_pending = ms_valid & (|load_op_q) & ~ready_go;

    assign ms2ws_bus = {vaddr_q, pc_q, csr_zip_q, except_zip_q};
    assign ms_rf_zip = {csr_re_q, rf_we_q, rf_waddr_q, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_BU = 5'b01000;
    localparam logic [4:0] LD_H  = 5'b00100;
    localparam logic [4:0] LD_HU = 5'b00010;
    localparam logic [4:0] LD_W  = 5'b00001;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         es2ms_valid = 1'b0;
    logic [194:0] es2ms_bus = '0;
    logic         ms_allowin;
    logic         data_sram_data_ok = 1'b0;
    logic [31:0]  data_sram_rdata = '0;
    logic         ws_allowin = 1'b1;
    logic         ms2ws_valid;
    logic [149:0] ms2ws_bus;
    logic [38:0]  ms_rf_zip;
    logic         ms_load_pending;
    logic         ms_ex;
    logic         wb_ex = 1'b0;
    logic         ertn_flush = 1'b0;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .es2ms_valid(es2ms_valid), .es2ms_bus(es2ms_bus), .ms_allowin(ms_allowin),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ws_allowin(ws_allowin), .ms2ws_valid(ms2ws_valid), .ms2ws_bus(ms2ws_bus),
        .ms_rf_zip(ms_rf_zip), .ms_load_pending(ms_load_pending), .ms_ex(ms_ex),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [194:0] mk(input logic [31:0] pc, input logic [31:0] vaddr,
                                        input logic [6:0] exc, input logic [4:0] lop,
                                        input logic mreq, input logic rfwe,
                                        input logic [4:0] wa, input logic [31:0] res);
        logic [78:0] csr;
        csr = {15'h1234, pc, ~vaddr};
        return {pc, vaddr, csr, exc, lop, mreq, 1'b0, rfwe, wa, res};
    endfunction

    // Load value from the architectural definition: pick the addressed byte or
    // halfword of the little-endian word and extend it.
    function automatic logic [31:0] ref_load(input logic [4:0] lop, input logic [31:0] addr,
                                             input logic [31:0] d);
        int          sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = int'(addr[1:0]) * 8;
        b  = 8'(d >> sh);
        h  = 16'(d >> (addr[1] ? 16 : 0));
        case (lop)
            LD_B:    return 32'($signed(b));
            LD_BU:   return {24'b0, b};
            LD_H:    return 32'($signed(h));
            LD_HU:   return {16'b0, h};
            default: return d;
        endcase
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if ({ms_allowin, ms2ws_valid, ms_load_pending, ms_ex} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 1000", {ms_allowin, ms2ws_valid, ms_load_pending, ms_ex});
        end
        checks++;
        if ({ms2ws_bus, ms_rf_zip} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got %h/%h want 0", ms2ws_bus, ms_rf_zip);
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_ld_b();
        tick();
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h100, 32'h1003, 7'd0, LD_B, 1'b1, 1'b1, 5'd3, 32'h0);
        ws_allowin  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            es2ms_valid = 1'b0;
            #1;
            checks++;
            if ({ms_load_pending, ms2ws_valid} !== 2'b10) begin
                errors++;
                $display("FAIL ldb_wait%0d: got pend/valid=%b want 10", i, {ms_load_pending, ms2ws_valid});
            end
        end
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80AA_BBCC;
        #1;
        checks++;
        if ({ms_load_pending, ms2ws_valid} !== 2'b01) begin
            errors++;
            $display("FAIL ldb_done: got pend/valid=%b want 01", {ms_load_pending, ms2ws_valid});
        end
        checks++;
        if (ms_rf_zip[37:0] !== {1'b1, 5'd3, 32'hFFFF_FF80}) begin
            errors++;
            $display("FAIL ldb_rf: got %h want %h", ms_rf_zip[37:0], {1'b1, 5'd3, 32'hFFFF_FF80});
        end
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        checks++;
        if ({ms2ws_valid, ms_allowin} !== 2'b01) begin
            errors++;
            $display("FAIL ldb_left: got valid/allowin=%b want 01", {ms2ws_valid, ms_allowin});
        end
    endtask

    task automatic test_ld_hu_stall();
        tick();
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h104, 32'h1002, 7'd0, LD_HU, 1'b1, 1'b1, 5'd7, 32'h0);
        tick();
        es2ms_valid       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_1234;
        ws_allowin        = 1'b0;
        #1;
        checks++;
        if ({ms2ws_valid, ms_rf_zip[31:0]} !== {1'b1, 32'h0000_8001}) begin
            errors++;
            $display("FAIL ldhu_ok: got valid=%b wdata=%h want 1/00008001", ms2ws_valid, ms_rf_zip[31:0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
            #1;
            checks++;
            if ({ms2ws_valid, ms_allowin, ms_rf_zip[31:0]} !== {2'b10, 32'h0000_8001}) begin
                errors++;
                $display("FAIL ldhu_hold%0d: got valid/allowin=%b wdata=%h want 10/00008001",
                         i, {ms2ws_valid, ms_allowin}, ms_rf_zip[31:0]);
            end
        end
        tick();
        ws_allowin = 1'b1;
        #1;
        checks++;
        if ({ms2ws_valid, ms_allowin, ms_rf_zip[31:0]} !== {2'b11, 32'h0000_8001}) begin
            errors++;
            $display("FAIL ldhu_release: got valid/allowin=%b wdata=%h want 11/00008001",
                     {ms2ws_valid, ms_allowin}, ms_rf_zip[31:0]);
        end
        tick();
        #1;
        checks++;
        if (ms2ws_valid !== 1'b0) begin
            errors++;
            $display("FAIL ldhu_gone: got valid=%b want 0", ms2ws_valid);
        end
    endtask

    task automatic test_flush_discard();
        tick();
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h108, 32'h2000, 7'd0, LD_W, 1'b1, 1'b1, 5'd4, 32'h0);
        tick();
        es2ms_valid = 1'b0;
        wb_ex       = 1'b1;
        tick();
        wb_ex = 1'b0;
        #1;
        checks++;
        if ({ms2ws_valid, ms_allowin, ms_load_pending} !== 3'b010) begin
            errors++;
            $display("FAIL flush_clear: got valid/allowin/pend=%b want 010",
                     {ms2ws_valid, ms_allowin, ms_load_pending});
        end
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h10C, 32'h2004, 7'd0, LD_W, 1'b1, 1'b1, 5'd5, 32'h0);
        tick();
        es2ms_valid       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({ms2ws_valid, ms_load_pending} !== 2'b01) begin
            errors++;
            $display("FAIL flush_drop: got valid/pend=%b want 01", {ms2ws_valid, ms_load_pending});
        end
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        checks++;
        if ({ms2ws_valid, ms_load_pending} !== 2'b01) begin
            errors++;
            $display("FAIL flush_wait: got valid/pend=%b want 01", {ms2ws_valid, ms_load_pending});
        end
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        #1;
        checks++;
        if ({ms2ws_valid, ms_rf_zip[31:0]} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL flush_deliver: got valid=%b wdata=%h want 1/12345678", ms2ws_valid, ms_rf_zip[31:0]);
        end
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            tick();
            es2ms_valid = 1'b1;
            es2ms_bus   = mk(32'h200 + 32'(4 * i), 32'h0, 7'd0, 5'd0, 1'b0, 1'b1, 5'(i + 1), 32'h55 + 32'(i));
            #1;
            checks++;
            if (ms_allowin !== 1'b1) begin
                errors++;
                $display("FAIL b2b_allowin%0d: got %b want 1", i, ms_allowin);
            end
            if (i > 0) begin
                checks++;
                if ({ms2ws_valid, ms_rf_zip[37:0]} !== {1'b1, 1'b1, 5'(i), 32'h55 + 32'(i - 1)}) begin
                    errors++;
                    $display("FAIL b2b_out%0d: got valid=%b rf=%h want 1/%h", i, ms2ws_valid,
                             ms_rf_zip[37:0], {1'b1, 5'(i), 32'h55 + 32'(i - 1)});
                end
            end
        end
        tick();
        es2ms_valid = 1'b0;
        #1;
        checks++;
        if ({ms2ws_valid, ms_rf_zip[31:0]} !== {1'b1, 32'h5A}) begin
            errors++;
            $display("FAIL b2b_last: got valid=%b wdata=%h want 1/0000005a", ms2ws_valid, ms_rf_zip[31:0]);
        end
        tick();
    endtask

    task automatic test_except();
        tick();
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h300, 32'h44, 7'b0000010, 5'd0, 1'b0, 1'b1, 5'd9, 32'h77);
        tick();
        es2ms_valid = 1'b0;
        ws_allowin  = 1'b0;
        #1;
        checks++;
        if ({ms_ex, ms_rf_zip[37], ms2ws_valid, ms2ws_bus[6:0]} !== {3'b101, 7'h02}) begin
            errors++;
            $display("FAIL except: got ex/we/valid=%b exc=%h want 101/02",
                     {ms_ex, ms_rf_zip[37], ms2ws_valid}, ms2ws_bus[6:0]);
        end
        checks++;
        if (ms2ws_bus[117:86] !== 32'h300) begin
            errors++;
            $display("FAIL except_pc: got %h want 00000300", ms2ws_bus[117:86]);
        end
        tick();
        ws_allowin = 1'b1;
        tick();
        #1;
        checks++;
        if (ms_ex !== 1'b0) begin
            errors++;
            $display("FAIL except_gone: got ms_ex=%b want 0", ms_ex);
        end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h400, 32'h3000, 7'd0, LD_W, 1'b1, 1'b1, 5'd2, 32'h0);
        tick();
        es2ms_valid = 1'b0;
        wb_ex       = 1'b1;
        tick();
        wb_ex       = 1'b0;
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h404, 32'h3004, 7'd0, LD_W, 1'b1, 1'b1, 5'd2, 32'h0);
        tick();
        es2ms_valid = 1'b0;
        #1;
        checks++;
        if (ms_load_pending !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got pend=%b want 1", ms_load_pending);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({ms_allowin, ms2ws_valid, ms_load_pending, ms_ex} !== 4'b1000 || ms2ws_bus !== '0 || ms_rf_zip !== '0) begin
            errors++;
            $display("FAIL rst_async: got ctl=%b bus=%h rf=%h want 1000/0/0",
                     {ms_allowin, ms2ws_valid, ms_load_pending, ms_ex}, ms2ws_bus, ms_rf_zip);
        end
        tick();
        reset       = 1'b0;
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h500, 32'h3008, 7'd0, LD_W, 1'b1, 1'b1, 5'd9, 32'h0);
        tick();
        es2ms_valid       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        checks++;
        if ({ms2ws_valid, ms_rf_zip[31:0]} !== {1'b1, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL rst_after: got valid=%b wdata=%h want 1/cafef00d", ms2ws_valid, ms_rf_zip[31:0]);
        end
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    // Random traffic against a model that only tracks "is an instruction held,
    // does it need memory data, has that data arrived".
    task automatic test_random();
        logic        occ = 0, m_mem = 0, m_load = 0, m_got = 0, m_we = 0, m_ex = 0;
        logic [31:0] m_pc = 0, m_wdata = 0, m_rd = 0;
        logic        n_mem = 0, n_we = 0;
        logic [4:0]  n_lop = 0;
        logic [6:0]  n_exc = 0;
        logic [31:0] n_pc = 0, n_va = 0, n_rd = 0, n_res = 0;
        logic        r_wait = 0, dok = 0, cap = 0, leave = 0, exp_rg, exp_v, exp_alw;
        int          r_delay = 0;
        tick();
        reset = 1'b1;
        tick();
        reset             = 1'b0;
        es2ms_valid       = 1'b0;
        data_sram_data_ok = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (leave) occ = 0;
            else if (dok) m_got = 1;
            if (cap) begin
                occ = 1; m_mem = n_mem; m_load = (n_lop != 0); m_got = 0;
                m_pc = n_pc; m_rd = n_rd; m_ex = (n_exc != 0);
                m_we = n_we && (n_exc == 0);
                m_wdata = (n_lop != 0) ? ref_load(n_lop, n_va, n_rd) : n_res;
                if (n_mem) begin r_wait = 1; r_delay = $urandom_range(0, 3); end
            end
            ws_allowin = ($urandom_range(0, 3) != 0);
            dok = r_wait && (r_delay == 0);
            if (r_wait) begin
                if (r_delay == 0) r_wait = 0;
                else r_delay--;
            end
            data_sram_data_ok = dok;
            data_sram_rdata   = dok ? m_rd : $urandom;
            if (cap || !es2ms_valid) begin
                es2ms_valid = ($urandom_range(0, 3) != 0);
                n_pc = $urandom; n_va = $urandom; n_rd = $urandom; n_res = $urandom;
                n_we = 1'($urandom_range(0, 1)); n_exc = 0; n_lop = 0; n_mem = 0;
                case ($urandom_range(0, 7))
                    0: begin n_lop = LD_B;  n_mem = 1; end
                    1: begin n_lop = LD_BU; n_mem = 1; end
                    2: begin n_lop = LD_H;  n_mem = 1; end
                    3: begin n_lop = LD_HU; n_mem = 1; end
                    4: begin n_lop = LD_W;  n_mem = 1; end
                    5: n_mem = 1;
                    6: n_exc = 7'(1 << $urandom_range(0, 6));
                    default: ;
                endcase
                es2ms_bus = mk(n_pc, n_va, n_exc, n_lop, n_mem, n_we, 5'(cyc), n_res);
            end
            exp_rg  = !m_mem || m_got || dok;
            exp_v   = occ && exp_rg;
            exp_alw = !occ || (exp_rg && ws_allowin);
            #1;
            checks++;
            if ({ms2ws_valid, ms_allowin, ms_load_pending, ms_ex} !==
                {exp_v, exp_alw, occ && m_load && !exp_rg, occ && m_ex}) begin
                errors++;
                $display("FAIL rand_ctl c%0d: got valid/allowin/pend/ex=%b want %b", cyc,
                         {ms2ws_valid, ms_allowin, ms_load_pending, ms_ex},
                         {exp_v, exp_alw, occ && m_load && !exp_rg, occ && m_ex});
            end
            if (exp_v) begin
                checks++;
                if ({ms2ws_bus[117:86], ms_rf_zip[37], ms_rf_zip[31:0]} !== {m_pc, m_we, m_wdata}) begin
                    errors++;
                    $display("FAIL rand_data c%0d: got pc=%h we=%b wdata=%h want pc=%h we=%b wdata=%h", cyc,
                             ms2ws_bus[117:86], ms_rf_zip[37], ms_rf_zip[31:0], m_pc, m_we, m_wdata);
                end
            end
            leave = exp_v && ws_allowin;
            cap   = es2ms_valid && exp_alw;
        end
        tick();
        es2ms_valid       = 1'b0;
        data_sram_data_ok = 1'b0;
        ws_allowin        = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ld_b();
        test_ld_hu_stall();
        test_flush_discard();
        test_back_to_back();
        test_except();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage between execute and writeback.
- Accepts one instruction per handshake from execute and waits for the data-memory response when the instruction issued a load or store request.
- Extracts and sign/zero-extends load data, then presents the writeback bus and register-file bus to the writeback stage.
- Provides a forwarding/stall view to decode and an exception indication to execute. It drops stale memory responses after a pipeline flush.

Parameters:
- ES2MS_LEN, 195, execute-to-mem bus width; fixed by the field list below.
- MS2WS_LEN, 150, mem-to-writeback bus width: {vaddr[31:0], pc[31:0], csr_zip[78:0], except_zip[6:0]}.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- es2ms_valid  in  1  execute holds a valid instruction
- es2ms_bus  in  195  {pc[31:0], vaddr[31:0], csr_zip[78:0], except_zip[6:0], load_op[4:0] = {ld_b, ld_bu, ld_h, ld_hu, ld_w}, mem_req, csr_re, rf_we, rf_waddr[4:0], result[31:0]}
- ms_allowin  out  1  stage can accept from execute
- data_sram_data_ok  in  1  data-memory response strobe, one per issued request, in order
- data_sram_rdata  in  32  response data, valid with data_ok
- ws_allowin  in  1  writeback can accept
- ms2ws_valid  out  1  bus to writeback is valid
- ms2ws_bus  out  150  {vaddr, pc, csr_zip, except_zip}
- ms_rf_zip  out  39  {csr_re, rf_we_q, rf_waddr, rf_wdata}
- ms_load_pending  out  1  valid load whose data has not yet arrived; decode stalls on it
- ms_ex  out  1  valid instruction carries an exception or ertn; execute suppresses new stores
- wb_ex  in  1  flush from writeback (exception)
- ertn_flush  in  1  flush from writeback (ertn)

Behaviour:
- Reset values (async): ms_valid=0, all payload registers=0, data_buf_valid=0, discard=0. Consequently ms2ws_valid=0, ms_load_pending=0, ms_ex=0 and both buses read 0. ms_allowin=1 in reset.
- except_zip bit order is {ale, adef, ine, int, brk, sys, ertn}.
- Execute never sets mem_req when except_zip[6:1] is non-zero.
- Capture: on posedge, when es2ms_valid & ms_allowin, latch es2ms_bus and set ms_valid=1. Otherwise, when ms_allowin is high, ms_valid <= es2ms_valid.
- Flush: wb_ex|ertn_flush clears ms_valid on the next edge; this has priority over capture.
- ready_go = ~mem_req_q | data_buf_valid | (data_sram_data_ok & ~discard).
- ms_allowin = ~ms_valid | (ready_go & ws_allowin).
- ms2ws_valid = ms_valid & ready_go.
- Response buffer (states EMPTY/FULL):
  - EMPTY->FULL when ms_valid & mem_req_q & data_ok & ~discard & ~ws_allowin; data_buf <= rdata.
  - FULL->EMPTY when the instruction leaves (ms2ws_valid & ws_allowin) or on flush.
  - Data used = data_buf_valid ? data_buf : data_sram_rdata.
- Discard:
  - Set on flush when ms_valid & mem_req_q & ~data_buf_valid & ~data_ok, i.e. the request is outstanding.
  - Cleared on the next data_ok; that response is ignored.
  - While discard=1, a newly captured request's ready_go ignores data_ok until discard clears.
  - Flush with data_ok in the same cycle: the response is consumed and discard stays 0.
- Load data: byte = data >> (8*vaddr[1:0]); half = vaddr[1] ? data[31:16] : data[15:0].
  - ld_b / ld_bu sign-/zero-extend the byte.
  - ld_h / ld_hu sign-/zero-extend the half.
  - ld_w takes data as is.
  - rf_wdata = (|load_op) ? load_value : result.
- rf_we_q = rf_we & ms_valid & ~ms_ex.
- ms_ex = ms_valid & |except_zip.
- ms_load_pending = ms_valid & (|load_op) & ~ready_go.
- ms2ws_bus is driven from the latched fields regardless of ms_valid; writeback qualifies it with ms2ws_valid.
- Reset mid-wait: all state clears, including discard, with no residual response handling.

Test Plan:
- ld_b, vaddr=0x1003, data_ok 2 cycles after capture with rdata=0x80AA_BBCC:
  - ms_load_pending=1 for 2 cycles, then ms2ws_valid=1.
  - ms_rf_zip wdata=0xFFFF_FF80, we=1.
- ld_hu, vaddr=0x1002, rdata=0x8001_1234, ws_allowin low for 3 cycles after data_ok:
  - data buffered; output wdata=0x0000_8001 held stable until ws_allowin=1, then released in 1 cycle.
- Load waiting, wb_ex pulsed before data_ok:
  - ms_valid=0 next cycle and discard=1.
  - New ld_w captured; first data_ok (0xDEAD_BEEF) dropped; second data_ok (0x1234_5678) delivered as wdata.
- Non-memory ALU op, result=0x55, rf_we=1, ws_allowin=1:
  - ms2ws_valid on the cycle after capture; wdata=0x55.
  - Back-to-back captures every cycle, ms_allowin constantly 1.
- Captured instruction with except_zip=7'b0000010 (sys):
  - ms_ex=1; ms_rf_zip we=0; ms2ws_bus carries except_zip=0x02.
- reset asserted asynchronously while a load waits with discard=1:
  - all outputs 0 immediately; after release, ms_allowin=1 and the next data_ok is not dropped.
